// File: rtl/dc_pkg.sv
// Shared definitions for the DC-frame FIFO link. Both the packer (producer)
// and the downstream frame dispatcher import these so the marker value and
// header layout can never drift apart between the two ends of the link.
package dc_pkg;

  // Packer sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SEND_HDR     = 3'd1,
    ST_SEND_PAYLOAD = 3'd2,
    ST_SEND_MARK    = 3'd3,
    ST_SEND_LAUNCH  = 3'd4
  } dc_pack_state_e;

  // A header always has exactly one zero in its channel field, so an
  // all-ones word is unambiguous as the launch marker.
  localparam logic [31:0] DC_LAUNCH_MARKER = 32'hFFFF_FFFF;
  localparam int          DC_LAUNCH_WORDS  = 4;
  localparam int          DC_HDR_CH_LSB    = 8;

endpackage

// File: rtl/dc_hdr_encode.sv
// Combinational DC-frame header encoder: low byte passes through, the
// channel field is all ones except a single zero at the target channel.
// Also flags channel numbers outside the DAC range.
module dc_hdr_encode
  import dc_pkg::*;
#(
  parameter int DAC_CHANNEL = 24
) (
  input  logic [4:0]  i_channel,
  input  logic [7:0]  i_hdr_lo,
  output logic [31:0] o_header,
  output logic        o_channel_err
);

  logic [5:0]  w_bit_pos;
  logic [31:0] w_clear_mask;

  // Out-of-range channels shift the mask off the top; the header is then
  // unused because the request is rejected.
  assign w_bit_pos     = {1'b0, i_channel} + 6'(DC_HDR_CH_LSB);
  assign w_clear_mask  = 32'd1 << w_bit_pos;
  assign o_channel_err = ({27'd0, i_channel} >= 32'(DAC_CHANNEL));
  assign o_header      = {~w_clear_mask[31:DC_HDR_CH_LSB], i_hdr_lo};

endmodule

// File: rtl/dc_frame_packer.sv
// DC-frame packer: serialises DC register frames (header + payload) and
// launch commands (marker + command words) onto the write port of the DC
// command FIFO. Writes stall word-for-word on FIFO full; data is taken from
// registered buffers so it stays stable while stalled.
// Optional launch path: define DC_FRAME_PACKER_LAUNCH_EN to include it.
module dc_frame_packer
  import dc_pkg::*;
#(
  parameter int DAC_CHANNEL = 24,
  parameter int FRAME_WORDS = 62
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_frame_valid,
  output logic                         o_frame_ready,
  input  logic [4:0]                   i_channel,
  input  logic [7:0]                   i_hdr_lo,
  input  logic [FRAME_WORDS-1:1][31:0] i_dc_payload,
  input  logic                         i_launch_valid,
  output logic                         o_launch_ready,
  input  logic [3:0][31:0]             i_launch_cmd,
  output logic [31:0]                  o_fifo_data,
  output logic                         o_fifo_wr,
  input  logic                         i_fifo_full,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic                         o_launch_done,
  output logic                         o_err_channel
);

  localparam logic [5:0] LAST_PAYLOAD_CNT = 6'(FRAME_WORDS - 1);

  dc_pack_state_e              r_state;
  dc_pack_state_e              w_next_state;
  logic [5:0]                  r_word_cnt;
  logic [31:0]                 r_hdr;
  logic [FRAME_WORDS-1:1][31:0] r_payload;
  logic                        r_frame_done;
  logic                        r_err_channel;
  logic [31:0]                 w_hdr;
  logic                        w_ch_err;
  logic                        w_frame_acc;

  dc_hdr_encode #(
    .DAC_CHANNEL (DAC_CHANNEL)
  ) u_hdr_encode (
    .i_channel     (i_channel),
    .i_hdr_lo      (i_hdr_lo),
    .o_header      (w_hdr),
    .o_channel_err (w_ch_err)
  );

  // Frame handshake; invalid channels complete the handshake but do not send.
  assign w_frame_acc = (r_state == ST_IDLE) && i_frame_valid && o_frame_ready;

`ifdef DC_FRAME_PACKER_LAUNCH_EN
  localparam logic [5:0] LAST_LAUNCH_CNT = 6'(DC_LAUNCH_WORDS - 1);

  logic [3:0][31:0] r_launch_cmd;
  logic             r_launch_done;
  logic             w_launch_acc;

  assign w_launch_acc  = (r_state == ST_IDLE) && i_launch_valid;
  assign o_launch_done = r_launch_done;

  // Capture the launch command words on accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_launch_cmd <= '0;
    end else if (w_launch_acc) begin
      r_launch_cmd <= i_launch_cmd;
    end
  end

  // Launch-done pulse once the last command word is actually written.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_launch_done <= 1'b0;
    end else begin
      r_launch_done <= (r_state == ST_SEND_LAUNCH) && o_fifo_wr &&
                       (r_word_cnt == LAST_LAUNCH_CNT);
    end
  end
`else
  logic w_unused_launch;
  assign w_unused_launch = ^{i_launch_valid, i_launch_cmd};
  assign o_launch_done   = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; progress only on cycles where a word is written.
  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_frame_acc && !w_ch_err) w_next_state = ST_SEND_HDR;
`ifdef DC_FRAME_PACKER_LAUNCH_EN
        if (w_launch_acc)             w_next_state = ST_SEND_MARK;
`endif
      end
      ST_SEND_HDR: begin
        if (o_fifo_wr) w_next_state = ST_SEND_PAYLOAD;
      end
      ST_SEND_PAYLOAD: begin
        if (o_fifo_wr && (r_word_cnt == LAST_PAYLOAD_CNT)) w_next_state = ST_IDLE;
      end
`ifdef DC_FRAME_PACKER_LAUNCH_EN
      ST_SEND_MARK: begin
        if (o_fifo_wr) w_next_state = ST_SEND_LAUNCH;
      end
      ST_SEND_LAUNCH: begin
        if (o_fifo_wr && (r_word_cnt == LAST_LAUNCH_CNT)) w_next_state = ST_IDLE;
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: readys in IDLE, write strobe and data in send states.
  always_comb begin
    o_frame_ready  = 1'b0;
    o_launch_ready = 1'b0;
    o_fifo_wr      = 1'b0;
    o_fifo_data    = '0;
    o_busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
`ifdef DC_FRAME_PACKER_LAUNCH_EN
        o_launch_ready = 1'b1;
        o_frame_ready  = !i_launch_valid;
`else
        o_frame_ready  = 1'b1;
`endif
      end
      ST_SEND_HDR: begin
        o_fifo_wr   = !i_fifo_full;
        o_fifo_data = r_hdr;
      end
      ST_SEND_PAYLOAD: begin
        o_fifo_wr   = !i_fifo_full;
        o_fifo_data = r_payload[r_word_cnt];
      end
`ifdef DC_FRAME_PACKER_LAUNCH_EN
      ST_SEND_MARK: begin
        o_fifo_wr   = !i_fifo_full;
        o_fifo_data = DC_LAUNCH_MARKER;
      end
      ST_SEND_LAUNCH: begin
        o_fifo_wr   = !i_fifo_full;
        o_fifo_data = r_launch_cmd[r_word_cnt[1:0]];
      end
`endif
      default: ;
    endcase
  end

  // Word counter: payload index 1..FRAME_WORDS-1, launch index 0..3.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        ST_SEND_HDR: begin
          if (o_fifo_wr) r_word_cnt <= 6'd1;
        end
        ST_SEND_PAYLOAD: begin
          if (o_fifo_wr) r_word_cnt <= (r_word_cnt == LAST_PAYLOAD_CNT) ? 6'd0 : r_word_cnt + 6'd1;
        end
        ST_SEND_MARK: begin
          if (o_fifo_wr) r_word_cnt <= 6'd0;
        end
        ST_SEND_LAUNCH: begin
          if (o_fifo_wr) r_word_cnt <= r_word_cnt + 6'd1;
        end
        default: r_word_cnt <= 6'd0;
      endcase
    end
  end

  // Capture header and payload on a valid frame accept.
  // NOTE: the frame buffers are cleared on reset so FIFO data after reset
  // is deterministic; this costs reset routing on every buffer flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hdr     <= '0;
      r_payload <= '0;
    end else if (w_frame_acc && !w_ch_err) begin
      r_hdr     <= w_hdr;
      r_payload <= i_dc_payload;
    end
  end

  // One-cycle status pulses: frame completed, channel rejected.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_done  <= 1'b0;
      r_err_channel <= 1'b0;
    end else begin
      r_frame_done  <= (r_state == ST_SEND_PAYLOAD) && o_fifo_wr &&
                       (r_word_cnt == LAST_PAYLOAD_CNT);
      r_err_channel <= w_frame_acc && w_ch_err;
    end
  end

  assign o_frame_done  = r_frame_done;
  assign o_err_channel = r_err_channel;

endmodule

// File: tb/tb_dc_frame_packer.sv
// Self-checking bench for dc_frame_packer. Expected FIFO words are queued
// when a request is accepted; a monitor pops and compares on every write.
// Launch-path sequences are exercised when DC_FRAME_PACKER_LAUNCH_EN is set.
module tb_dc_frame_packer;

  localparam int DAC_CHANNEL = 24;
  localparam int FRAME_WORDS = 62;

  logic                         clk = 1'b0;
  logic                         i_rst;
  logic                         i_frame_valid;
  logic                         o_frame_ready;
  logic [4:0]                   i_channel;
  logic [7:0]                   i_hdr_lo;
  logic [FRAME_WORDS-1:1][31:0] i_dc_payload;
  logic                         i_launch_valid;
  logic                         o_launch_ready;
  logic [3:0][31:0]             i_launch_cmd;
  logic [31:0]                  o_fifo_data;
  logic                         o_fifo_wr;
  logic                         i_fifo_full;
  logic                         o_busy;
  logic                         o_frame_done;
  logic                         o_launch_done;
  logic                         o_err_channel;

  dc_frame_packer #(
    .DAC_CHANNEL (DAC_CHANNEL),
    .FRAME_WORDS (FRAME_WORDS)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_frame_valid  (i_frame_valid),
    .o_frame_ready  (o_frame_ready),
    .i_channel      (i_channel),
    .i_hdr_lo       (i_hdr_lo),
    .i_dc_payload   (i_dc_payload),
    .i_launch_valid (i_launch_valid),
    .o_launch_ready (o_launch_ready),
    .i_launch_cmd   (i_launch_cmd),
    .o_fifo_data    (o_fifo_data),
    .o_fifo_wr      (o_fifo_wr),
    .i_fifo_full    (i_fifo_full),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done),
    .o_launch_done  (o_launch_done),
    .o_err_channel  (o_err_channel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Scoreboard monitor: every FIFO write must match the next queued word.
  always @(negedge clk) begin
    if (o_fifo_wr === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) check("unexpected_wr", {31'd0, o_fifo_wr}, 32'd0);
      else                   check("fifo_word", o_fifo_data, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int c);
    while (cyc < c) step();
  endtask

  task automatic at(input int c);
    go(c);
    @(negedge clk);
  endtask

  task automatic set_payload(input int base);
    for (int k = 1; k < FRAME_WORDS; k++) i_dc_payload[k] = 32'(base + k);
  endtask

  task automatic push_frame(input logic [31:0] hdr, input int base);
    exp_q.push_back(hdr);
    for (int k = 1; k < FRAME_WORDS; k++) exp_q.push_back(32'(base + k));
  endtask

  // Issue a frame request; returns the accept cycle. Called just after a
  // posedge, returns just after the posedge that starts cycle t+1.
  task automatic send_frame(input logic [4:0] ch, input logic [7:0] lo,
                            input logic [31:0] hdr, input int base,
                            input bit sends, output int t);
    int guard;
    i_channel     = ch;
    i_hdr_lo      = lo;
    set_payload(base);
    i_frame_valid = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!o_frame_ready && guard < 100) begin
      step();
      @(negedge clk);
      guard++;
    end
    chk1("frame_ready_wait", o_frame_ready, 1'b1);
    t = cyc;
    if (sends) push_frame(hdr, base);
    step();
    i_frame_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, stuck at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int t2;
    int w0;
    int guard;
    logic [31:0] d_hold;

    i_rst          = 1'b1;
    i_frame_valid  = 1'b0;
    i_launch_valid = 1'b0;
    i_channel      = '0;
    i_hdr_lo       = '0;
    i_dc_payload   = '0;
    i_launch_cmd   = '0;
    i_fifo_full    = 1'b0;
    repeat (3) step();
    i_rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk1("rst_fifo_wr", o_fifo_wr, 1'b0);
    check("rst_fifo_data", o_fifo_data, 32'd0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_frame_done", o_frame_done, 1'b0);
    chk1("rst_launch_done", o_launch_done, 1'b0);
    chk1("rst_err_channel", o_err_channel, 1'b0);
    chk1("rst_frame_ready", o_frame_ready, 1'b1);
`ifdef DC_FRAME_PACKER_LAUNCH_EN
    chk1("rst_launch_ready", o_launch_ready, 1'b1);
`else
    chk1("rst_launch_ready", o_launch_ready, 1'b0);
`endif
    step();

    // Basic frame, ch 5, payload k.
    w0 = n_writes;
    send_frame(5'd5, 8'hA5, 32'hFFFF_DFA5, 0, 1'b1, t);
    at(t + 1);
    chk1("frame_busy", o_busy, 1'b1);
    chk1("frame_ready_while_busy", o_frame_ready, 1'b0);
    chk1("launch_ready_while_busy", o_launch_ready, 1'b0);
    at(t + 62);
    chk1("frame_done_early", o_frame_done, 1'b0);
    at(t + 63);
    chk1("frame_done", o_frame_done, 1'b1);
    chk1("frame_ready_after", o_frame_ready, 1'b1);
    chk1("frame_idle_after", o_busy, 1'b0);
    check("frame_write_count", 32'(n_writes - w0), 32'd62);
    check("frame_queue_drained", 32'(exp_q.size()), 32'd0);
    step();

`ifdef DC_FRAME_PACKER_LAUNCH_EN
    // Launch command {4,3,2,1}.
    w0 = n_writes;
    i_launch_cmd   = {32'd4, 32'd3, 32'd2, 32'd1};
    i_launch_valid = 1'b1;
    @(negedge clk);
    chk1("launch_ready", o_launch_ready, 1'b1);
    t = cyc;
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd4);
    step();
    i_launch_valid = 1'b0;
    at(t + 5);
    chk1("launch_done_early", o_launch_done, 1'b0);
    at(t + 6);
    chk1("launch_done", o_launch_done, 1'b1);
    chk1("launch_ready_after", o_launch_ready, 1'b1);
    check("launch_write_count", 32'(n_writes - w0), 32'd5);
    step();
`endif

    // Invalid channel 24: accepted, nothing written, error pulse.
    w0 = n_writes;
    send_frame(5'd24, 8'h11, 32'd0, 600, 1'b0, t);
    at(t + 1);
    chk1("err_channel_pulse", o_err_channel, 1'b1);
    chk1("err_frame_ready", o_frame_ready, 1'b1);
    chk1("err_not_busy", o_busy, 1'b0);
    at(t + 2);
    chk1("err_channel_clear", o_err_channel, 1'b0);
    check("err_no_writes", 32'(n_writes - w0), 32'd0);
    step();

    // Backpressure at T+10..T+14.
    w0 = n_writes;
    send_frame(5'd12, 8'h81, 32'hFFEF_FF81, 100, 1'b1, t);
    go(t + 10);
    i_fifo_full = 1'b1;
    @(negedge clk);
    chk1("stall_no_wr", o_fifo_wr, 1'b0);
    d_hold = o_fifo_data;
    check("stall_word", d_hold, 32'd109);
    for (int c = t + 11; c <= t + 14; c++) begin
      go(c);
      @(negedge clk);
      chk1("stall_no_wr", o_fifo_wr, 1'b0);
      check("stall_data_hold", o_fifo_data, d_hold);
    end
    go(t + 15);
    i_fifo_full = 1'b0;
    at(t + 67);
    chk1("stall_done_early", o_frame_done, 1'b0);
    at(t + 68);
    chk1("stall_frame_done", o_frame_done, 1'b1);
    check("stall_write_count", 32'(n_writes - w0), 32'd62);
    step();

    // FIFO full in the last-word cycle delays the done pulse.
    w0 = n_writes;
    send_frame(5'd0, 8'h3C, 32'hFFFF_FE3C, 200, 1'b1, t);
    go(t + 62);
    i_fifo_full = 1'b1;
    @(negedge clk);
    chk1("last_word_stalled", o_fifo_wr, 1'b0);
    check("last_word_data", o_fifo_data, 32'd261);
    go(t + 63);
    i_fifo_full = 1'b0;
    @(negedge clk);
    chk1("last_word_written", o_fifo_wr, 1'b1);
    chk1("last_done_waits", o_frame_done, 1'b0);
    at(t + 64);
    chk1("last_frame_done", o_frame_done, 1'b1);
    check("last_write_count", 32'(n_writes - w0), 32'd62);
    step();

    // Frame and launch requested together.
    i_channel      = 5'd23;
    i_hdr_lo       = 8'h00;
    set_payload(300);
    i_launch_cmd   = {32'hD, 32'hC, 32'hB, 32'hA};
    i_frame_valid  = 1'b1;
    i_launch_valid = 1'b1;
    @(negedge clk);
    t = cyc;
`ifdef DC_FRAME_PACKER_LAUNCH_EN
    chk1("both_launch_ready", o_launch_ready, 1'b1);
    chk1("both_frame_blocked", o_frame_ready, 1'b0);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hB);
    exp_q.push_back(32'hC);
    exp_q.push_back(32'hD);
    step();
    i_launch_valid = 1'b0;
    @(negedge clk);
    guard = 0;
    while (!o_frame_ready && guard < 50) begin
      step();
      @(negedge clk);
      guard++;
    end
    t2 = cyc;
    check("frame_after_launch_cycle", 32'(t2 - t), 32'd6);
    chk1("frame_accept_on_launch_done", o_launch_done, 1'b1);
    check("launch_drained_first", 32'(exp_q.size()), 32'd0);
    push_frame(32'h7FFF_FF00, 300);
    step();
    i_frame_valid = 1'b0;
`else
    chk1("both_launch_ready_off", o_launch_ready, 1'b0);
    chk1("both_frame_ready", o_frame_ready, 1'b1);
    t2 = t;
    push_frame(32'h7FFF_FF00, 300);
    step();
    i_frame_valid  = 1'b0;
    i_launch_valid = 1'b0;
`endif
    at(t2 + 63);
    chk1("both_frame_done", o_frame_done, 1'b1);
    chk1("both_launch_done_clear", o_launch_done, 1'b0);
    check("both_queue_drained", 32'(exp_q.size()), 32'd0);
    step();

    // Reset while payload word 30 is written.
    send_frame(5'd5, 8'hA5, 32'hFFFF_DFA5, 400, 1'b1, t);
    go(t + 31);
    i_rst = 1'b1;
    @(negedge clk);
    chk1("rst_mid_word30_written", o_fifo_wr, 1'b1);
    step();
    exp_q.delete();
    @(negedge clk);
    chk1("rst_mid_no_wr", o_fifo_wr, 1'b0);
    check("rst_mid_data", o_fifo_data, 32'd0);
    chk1("rst_mid_busy", o_busy, 1'b0);
    chk1("rst_mid_frame_done", o_frame_done, 1'b0);
    chk1("rst_mid_err", o_err_channel, 1'b0);
    chk1("rst_mid_frame_ready", o_frame_ready, 1'b1);
    step();
    i_rst = 1'b0;
    w0 = n_writes;
    send_frame(5'd5, 8'hA5, 32'hFFFF_DFA5, 500, 1'b1, t);
    at(t + 63);
    chk1("post_rst_frame_done", o_frame_done, 1'b1);
    check("post_rst_write_count", 32'(n_writes - w0), 32'd62);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
